// File: rtl/hk_mash_ddsm.sv
// HK-MASH delta-sigma modulator: up to four chained HK error-feedback stages, noise-cancelled into a signed y_o.
// y_o is registered one edge after the carries it is built from; en=0 freezes the datapath (no backpressure beyond that).
module hk_mash_ddsm #(
  parameter int WIDTH  = 24,
  parameter int ORDER  = 3,
  parameter int A_GAIN = 1,
  parameter int DITHER = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [WIDTH-1:0]        x_i,
  input  logic                    x_load,
  input  logic [2:0]              ord_i,
  input  logic                    dither_en,
  output logic signed [ORDER:0]   y_o,
  output logic                    y_vld
);

  localparam logic [WIDTH:0] A_EXT = {{(WIDTH+1-A_GAIN){1'b0}}, {A_GAIN{1'b1}}};

  logic [WIDTH-1:0]            x_r;
  logic [2:0]                  ord_r;
  logic [2:0]                  ord_clamped;
  logic [2:0]                  ord_nxt;
  logic [ORDER-1:0][WIDTH:0]   s;
  logic [ORDER-1:0][WIDTH:0]   sum;
  logic [ORDER-1:0]            c;
  logic [WIDTH:0]              x_d;
  logic [WIDTH-1:0]            in1;
  logic [22:0]                 lfsr;
  logic                        d;
  logic signed [ORDER:0]       n  [ORDER+1];
  logic signed [ORDER:0]       nz [ORDER];   // nz[j] = n[j+1] from the previous enabled edge

  always_comb begin
    ord_clamped = ord_i;
    if (ord_i == 3'd0)
      ord_clamped = 3'd1;
    else if (ord_i > 3'(ORDER))
      ord_clamped = 3'(ORDER);
  end

  // Order only moves while the modulator is paused, and inactive stages are cleared on that same edge.
  assign ord_nxt = en ? ord_r : ord_clamped;

  assign d   = (DITHER != 0) && dither_en && lfsr[0];
  assign x_d = {1'b0, x_r} + {{WIDTH{1'b0}}, d};
  assign in1 = x_d[WIDTH] ? {WIDTH{1'b1}} : x_d[WIDTH-1:0];

  always_comb begin
    logic [WIDTH-1:0] in_k;
    in_k = in1;
    sum  = '0;
    c    = '0;
    for (int k = 0; k < ORDER; k++) begin
      c[k]   = s[k][WIDTH];
      sum[k] = {1'b0, in_k} + {1'b0, s[k][WIDTH-1:0]} + (c[k] ? A_EXT : '0);
      in_k   = sum[k][WIDTH-1:0];
    end
  end

  always_comb begin
    for (int k = 0; k <= ORDER; k++)
      n[k] = '0;
    for (int k = ORDER - 1; k >= 0; k--)
      n[k] = $signed({{ORDER{1'b0}}, c[k]}) + n[k+1] - nz[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r   <= '0;
      ord_r <= 3'(ORDER);
      s     <= '0;
      y_o   <= '0;
      y_vld <= 1'b0;
      for (int j = 0; j < ORDER; j++)
        nz[j] <= '0;
    end else begin
      if (x_load)
        x_r <= x_i;
      ord_r <= ord_nxt;
      y_vld <= en;
      if (en)
        y_o <= n[0];
      for (int k = 0; k < ORDER; k++) begin
        if (k + 1 > int'(ord_nxt))
          s[k] <= '0;
        else if (en)
          s[k] <= sum[k];
      end
      for (int j = 0; j < ORDER; j++) begin
        if (j + 1 >= int'(ord_nxt))
          nz[j] <= '0;
        else if (en)
          nz[j] <= n[j+1];
      end
    end
  end

  generate
    if (DITHER != 0) begin : g_lfsr
      // x^23 + x^18 + 1, newest bit enters at bit 0
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          lfsr <= 23'h1;
        else if (en)
          lfsr <= {lfsr[21:0], lfsr[22] ^ lfsr[17]};
      end
    end else begin : g_no_lfsr
      assign lfsr = 23'h1;
    end
  endgenerate

endmodule
